// File: rtl/sccb_responder.sv
// SCCB target model: decodes 3-phase writes, 2-phase writes and 2-phase
// reads from the bus master into an internal 8-bit register file, and
// drives SIO_D open-drain (low only) through siod_oe.
module sccb_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         NUM_REGS    = 256,
  parameter bit         ACK_DRIVE   = 1'b1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       xclk,
  input  logic       reset,
  input  logic       sioc,
  input  logic       siod_i,
  output logic       siod_oe,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_ID_ACK, S_SUB, S_SUB_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_NA, S_WAIT_STOP
  } state_t;

  function automatic logic in_range(input logic [7:0] a);
    return int'({24'd0, a}) < NUM_REGS;
  endfunction

  logic [SS-1:0] sioc_sync_q, sioc_sync_d, siod_sync_q, siod_sync_d;
  logic          sioc_prev_q, sioc_prev_d, siod_prev_q, siod_prev_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    ptr_q, ptr_d;
  logic          ack_ph_q, ack_ph_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [7:0]    wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          commit;

  logic sioc_s, siod_s, sioc_rise, sioc_fall, start_ev, stop_ev;
  logic [7:0] rd_val;

  assign sioc_s    = sioc_sync_q[SS-1];
  assign siod_s    = siod_sync_q[SS-1];
  assign sioc_rise = sioc_s & ~sioc_prev_q;
  assign sioc_fall = ~sioc_s & sioc_prev_q;
  assign start_ev  = sioc_s & sioc_prev_q & siod_prev_q & ~siod_s;
  assign stop_ev   = sioc_s & sioc_prev_q & ~siod_prev_q & siod_s;

  assign rd_val    = in_range(ptr_q) ? regs_q[ptr_q[AW-1:0]] : 8'h00;
  assign dbg_data  = in_range(dbg_addr) ? regs_q[dbg_addr[AW-1:0]] : 8'h00;

  assign siod_oe   = oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  // Synchronizers, bus event decode and the protocol state machine
  always_comb begin
    sioc_sync_d = {sioc_sync_q[SS-2:0], sioc};
    siod_sync_d = {siod_sync_q[SS-2:0], siod_i};
    sioc_prev_d = sioc_s;
    siod_prev_d = siod_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    ack_ph_d    = ack_ph_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    commit      = 1'b0;
    if (stop_ev) begin
      state_d  = S_IDLE;
      oe_d     = 1'b0;
      busy_d   = 1'b0;
      ack_ph_d = 1'b0;
    end else if (start_ev) begin
      state_d   = S_ID;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b1;
      oe_d      = 1'b0;
      ack_ph_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_ID, S_SUB, S_WDATA: begin
          if (sioc_rise) begin
            shift_d   = {shift_q[6:0], siod_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              case (state_q)
                S_ID: begin
                  // A foreign ID parks us until STOP without ever driving
                  if (shift_d[7:1] == DEVICE_ID[7:1]) begin
                    state_d = S_ID_ACK;
                    rw_d    = siod_s;
                  end else begin
                    state_d = S_WAIT_STOP;
                  end
                end
                S_SUB: begin
                  state_d = S_SUB_ACK;
                  ptr_d   = shift_d;
                end
                default: state_d = S_WDATA_ACK;
              endcase
            end
          end
        end
        S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
          if (sioc_fall) begin
            if (!ack_ph_q) begin
              ack_ph_d = 1'b1;
              oe_d     = ACK_DRIVE;
              if (state_q == S_WDATA_ACK) begin
                commit      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = shift_q;
              end
            end else begin
              ack_ph_d = 1'b0;
              oe_d     = 1'b0;
              case (state_q)
                S_ID_ACK: begin
                  if (rw_q) begin
                    // The edge ending the ack also presents read bit 7
                    state_d   = S_RDATA;
                    tx_d      = {rd_val[6:0], 1'b0};
                    oe_d      = ~rd_val[7];
                    bit_cnt_d = 4'd1;
                  end else begin
                    state_d   = S_SUB;
                    bit_cnt_d = 4'd0;
                  end
                end
                S_SUB_ACK: begin
                  state_d   = S_WDATA;
                  bit_cnt_d = 4'd0;
                end
                default: state_d = S_WAIT_STOP;
              endcase
            end
          end
        end
        S_RDATA: begin
          if (sioc_fall) begin
            if (bit_cnt_q == 4'd8) begin
              oe_d      = 1'b0;
              state_d   = S_RDATA_NA;
              bit_cnt_d = 4'd0;
            end else begin
              oe_d      = ~tx_q[7];
              tx_d      = {tx_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RDATA_NA: begin
          if (sioc_rise) state_d = S_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge xclk) begin
    if (reset) begin
      sioc_sync_q <= '1;
      siod_sync_q <= '1;
      sioc_prev_q <= 1'b1;
      siod_prev_q <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      ptr_q       <= 8'h00;
      ack_ph_q    <= 1'b0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 8'h00;
    end else begin
      sioc_sync_q <= sioc_sync_d;
      siod_sync_q <= siod_sync_d;
      sioc_prev_q <= sioc_prev_d;
      siod_prev_q <= siod_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      ack_ph_q    <= ack_ph_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
    shift_q <= shift_d;
    tx_q    <= tx_d;
  end

  // Register file next value: only a committed in-range write lands
  always_comb begin
    regs_d = regs_q;
    if (commit && in_range(ptr_q)) regs_d[ptr_q[AW-1:0]] = shift_q;
  end

  // Register file storage, cleared on reset
  always_ff @(posedge xclk) begin
    if (reset) regs_q <= '{default: 8'h00};
    else       regs_q <= regs_d;
  end

endmodule
